// File: rtl/multi_led_blinker_if.sv
// Configuration write port for multi_led_blinker: valid/ready handshake
// carrying target channel, mode, period and duty.
interface multi_led_blinker_if #(
   parameter int unsigned NUM_CH   = 3,
   parameter int unsigned PERIOD_W = 12
) ();
   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic                valid;
   logic                ready;
   logic [CH_W-1:0]     ch;
   logic [1:0]          mode;
   logic [PERIOD_W-1:0] period;
   logic [PERIOD_W-1:0] duty;

   modport master (output valid, ch, mode, period, duty, input ready);
   modport slave  (input valid, ch, mode, period, duty, output ready);
endinterface

// File: rtl/multi_led_blinker.sv
// N-channel LED pattern generator: shared tick prescaler plus per-channel
// period/duty phase counters running OFF / ON / BLINK / ONESHOT.
// Optional build macro MULTI_LED_BLINKER_ACTIVE_LOW_EN inverts the LED
// output register (reset value all 1, "on" drives 0).
module multi_led_blinker #(
   parameter int unsigned CLK_HZ     = 12000000,
   parameter int unsigned TICK_HZ    = 1000,
   parameter int unsigned NUM_CH     = 3,
   parameter int unsigned PERIOD_W   = 12,
   parameter int unsigned DEF_PERIOD = 1000,
   parameter int unsigned DEF_DUTY   = 500
) (
   input  logic                clk,
   input  logic                rst_n,
   multi_led_blinker_if.slave  cfg,
   output logic [NUM_CH-1:0]   led,
   output logic                tick
);

   localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
   localparam int unsigned PRE_W = $clog2(DIV);
   localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned CNT_W = PERIOD_W + 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

`ifdef MULTI_LED_BLINKER_ACTIVE_LOW_EN
   localparam logic ACTIVE_LOW = 1'b1;
`else
   localparam logic ACTIVE_LOW = 1'b0;
`endif
   localparam logic [NUM_CH-1:0] LED_MASK = {NUM_CH{ACTIVE_LOW}};

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_ON      = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_ONESHOT = 2'd3
   } mode_e;

   logic [PRE_W-1:0]    pre_q, pre_n;
   logic                tick_n;
   logic                ready_n;
   logic                accept;

   mode_e               mode_q   [NUM_CH];
   mode_e               mode_n   [NUM_CH];
   logic [PERIOD_W-1:0] period_q [NUM_CH];
   logic [PERIOD_W-1:0] period_n [NUM_CH];
   logic [PERIOD_W-1:0] duty_q   [NUM_CH];
   logic [PERIOD_W-1:0] duty_n   [NUM_CH];
   logic [PERIOD_W-1:0] phase_q  [NUM_CH];
   logic [PERIOD_W-1:0] phase_n  [NUM_CH];
   logic [CNT_W-1:0]    inc      [NUM_CH];
   logic [NUM_CH-1:0]   led_n;

   assign accept = cfg.valid & cfg.ready;

   // Prescaler wrap, tick strobe and one-cycle ready drop after each accept
   always_comb begin
      pre_n   = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
      tick_n  = (pre_q == PRE_LAST);
      ready_n = ~accept;
   end

   // Per-channel next state; a config write beats a coincident tick
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         mode_n[i]   = mode_q[i];
         period_n[i] = period_q[i];
         duty_n[i]   = duty_q[i];
         phase_n[i]  = phase_q[i];
         led_n[i]    = led[i] ^ ACTIVE_LOW;
         inc[i]      = {1'b0, phase_q[i]} + CNT_W'(1);

         if (accept && (cfg.ch == CH_W'(i))) begin
            // ONESHOT with zero on-time finishes at once
            if ((cfg.mode == MODE_ONESHOT) && (cfg.duty == '0)) begin
               mode_n[i] = MODE_OFF;
            end else begin
               mode_n[i] = mode_e'(cfg.mode);
            end
            period_n[i] = cfg.period;
            duty_n[i]   = cfg.duty;
            phase_n[i]  = '0;
         end else begin
            if (tick) begin
               if (mode_q[i] == MODE_ONESHOT) begin
                  if (inc[i] >= {1'b0, duty_q[i]}) begin
                     mode_n[i]  = MODE_OFF;
                     phase_n[i] = '0;
                  end else begin
                     phase_n[i] = inc[i][PERIOD_W-1:0];
                  end
               end else if (inc[i] >= {1'b0, period_q[i]}) begin
                  phase_n[i] = '0;
               end else begin
                  phase_n[i] = inc[i][PERIOD_W-1:0];
               end
            end

            case (mode_n[i])
               MODE_OFF: led_n[i] = 1'b0;
               MODE_ON:  led_n[i] = 1'b1;
               default:  led_n[i] = (phase_n[i] < duty_n[i]);
            endcase
         end
      end
   end

   // State registers with asynchronous reset to the default blink
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q     <= '0;
         tick      <= 1'b0;
         cfg.ready <= 1'b0;
         led       <= LED_MASK;
         for (int i = 0; i < NUM_CH; i++) begin
            mode_q[i]   <= MODE_BLINK;
            period_q[i] <= PERIOD_W'(DEF_PERIOD);
            duty_q[i]   <= PERIOD_W'(DEF_DUTY);
            phase_q[i]  <= '0;
         end
      end else begin
         pre_q     <= pre_n;
         tick      <= tick_n;
         cfg.ready <= ready_n;
         led       <= led_n ^ LED_MASK;
         for (int i = 0; i < NUM_CH; i++) begin
            mode_q[i]   <= mode_n[i];
            period_q[i] <= period_n[i];
            duty_q[i]   <= duty_n[i];
            phase_q[i]  <= phase_n[i];
         end
      end
   end

endmodule

// File: tb/tb_multi_led_blinker.sv
// Scoreboard bench for multi_led_blinker: stimulus pushes cycle-stamped
// expectations, a negedge monitor pops and compares them.
module tb_multi_led_blinker;

   localparam int K_LED   = 0;
   localparam int K_TICK  = 1;
   localparam int K_RDY   = 2;
   localparam int K_MODE  = 3;
   localparam int K_PHASE = 4;

`ifdef MULTI_LED_BLINKER_ACTIVE_LOW_EN
   localparam logic [7:0] POL = 8'h07;
`else
   localparam logic [7:0] POL = 8'h00;
`endif

   typedef struct {
      int         cyc;
      int         kind;
      int         idx;
      logic [7:0] mask;
      logic [7:0] val;
      bit [95:0]  name;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [2:0] led;
   logic       tick;

   int   cyc;
   int   base;
   int   n_cmp;
   int   n_fail;
   bit   finish_req;
   logic [7:0] act;
   exp_t sb[$];

   multi_led_blinker_if #(.NUM_CH(3), .PERIOD_W(12)) cfg_if ();

   multi_led_blinker #(
      .CLK_HZ(12000), .TICK_HZ(1000), .NUM_CH(3), .PERIOD_W(12),
      .DEF_PERIOD(10), .DEF_DUTY(5)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cfg(cfg_if), .led(led), .tick(tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(input int rel, input int kind, input int idx,
                       input logic [7:0] mask, input logic [7:0] val, input bit [95:0] nm);
      exp_t e;
      e.cyc  = base + rel;
      e.kind = kind;
      e.idx  = idx;
      e.mask = mask;
      e.val  = (kind == K_LED) ? (val ^ POL) : val;
      e.name = nm;
      sb.push_back(e);
   endtask

   task automatic wait_rel(input int k);
      while (cyc < base + k) @(negedge clk);
   endtask

   task automatic drive(input int ch, input int md, input int per, input int dty);
      cfg_if.ch     = 2'(ch);
      cfg_if.mode   = 2'(md);
      cfg_if.period = 12'(per);
      cfg_if.duty   = 12'(dty);
      cfg_if.valid  = 1'b1;
   endtask

   // Monitor: compares every expectation whose stamp has come due
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc <= cyc) begin
            case (sb[i].kind)
               K_LED:   act = 8'(led);
               K_TICK:  act = 8'(tick);
               K_RDY:   act = 8'(cfg_if.ready);
               K_MODE:  act = 8'(dut.mode_q[2]);
               default: act = 8'(dut.phase_q[sb[i].idx]);
            endcase
            n_cmp++;
            if ((sb[i].cyc < cyc) || ((act & sb[i].mask) !== (sb[i].val & sb[i].mask))) begin
               n_fail++;
               $display("FAIL %0s @cyc %0d (due %0d): got 0x%0h, expected 0x%0h",
                        sb[i].name, cyc, sb[i].cyc, act & sb[i].mask, sb[i].val & sb[i].mask);
            end
            sb.delete(i);
         end
      end
      if (finish_req) begin
         foreach (sb[j]) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %0s never checked (due %0d)", sb[j].name, sb[j].cyc);
         end
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
         $finish;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      cfg_if.valid = 1'b0; cfg_if.ch = '0; cfg_if.mode = '0;
      cfg_if.period = '0; cfg_if.duty = '0;
      base = 0; n_cmp = 0; n_fail = 0; finish_req = 1'b0;

      // In reset
      push(1, K_LED,  0, 8'h07, 8'h00, "rst_led");
      push(1, K_TICK, 0, 8'h01, 8'h00, "rst_tick");
      push(1, K_RDY,  0, 8'h01, 8'h00, "rst_rdy");
      push(3, K_RDY,  0, 8'h01, 8'h00, "rst_rdy2");

      wait_rel(3);
      #2 rst_n = 1'b1;
      base = 3;

      // Default 10-tick, 5-on blink on every channel
      push(1,   K_RDY,  0, 8'h01, 8'h01, "rdy_rise");
      push(1,   K_LED,  0, 8'h07, 8'h07, "dflt_on0");
      push(11,  K_TICK, 0, 8'h01, 8'h00, "tick_pre");
      push(12,  K_TICK, 0, 8'h01, 8'h01, "tick_1st");
      push(13,  K_TICK, 0, 8'h01, 8'h00, "tick_post");
      push(24,  K_TICK, 0, 8'h01, 8'h01, "tick_2nd");
      push(60,  K_LED,  0, 8'h07, 8'h07, "dflt_on60");
      push(61,  K_LED,  0, 8'h07, 8'h00, "dflt_off61");
      push(120, K_LED,  0, 8'h07, 8'h00, "dflt_off120");
      push(121, K_LED,  0, 8'h07, 8'h07, "dflt_on121");

      // Handshake: two back-to-back queued writes
      wait_rel(185);
      drive(1, 1, 0, 0);
      push(186, K_RDY, 0, 8'h01, 8'h00, "hs_rdy_lo1");
      push(187, K_RDY, 0, 8'h01, 8'h01, "hs_rdy_hi1");
      push(188, K_RDY, 0, 8'h01, 8'h00, "hs_rdy_lo2");
      push(189, K_RDY, 0, 8'h01, 8'h01, "hs_rdy_hi2");
      push(186, K_LED, 0, 8'h07, 8'h00, "hs_latency");
      push(187, K_LED, 0, 8'h07, 8'h02, "hs_ch1_on");
      push(188, K_LED, 0, 8'h07, 8'h02, "hs_ch2_wait");
      push(189, K_LED, 0, 8'h07, 8'h06, "hs_ch2_on");
      push(240, K_LED, 0, 8'h07, 8'h06, "hs_ch0_off");
      push(241, K_LED, 0, 8'h07, 8'h07, "hs_ch0_on");
      wait_rel(186);
      drive(2, 1, 0, 0);
      wait_rel(188);
      cfg_if.valid = 1'b0;

      // Boundaries on ch0
      wait_rel(250);
      drive(0, 2, 4, 0);
      push(252, K_LED, 0, 8'h01, 8'h00, "duty0_a");
      push(300, K_LED, 0, 8'h01, 8'h00, "duty0_b");
      wait_rel(251);
      cfg_if.valid = 1'b0;

      wait_rel(310);
      drive(0, 2, 4, 4);
      push(312, K_LED, 0, 8'h01, 8'h01, "dutyper_a");
      push(350, K_LED, 0, 8'h01, 8'h01, "dutyper_b");
      wait_rel(311);
      cfg_if.valid = 1'b0;

      wait_rel(360);
      drive(0, 2, 0, 3);
      push(362, K_LED, 0, 8'h01, 8'h01, "per0_a");
      push(400, K_LED, 0, 8'h01, 8'h01, "per0_b");
      wait_rel(361);
      cfg_if.valid = 1'b0;

      wait_rel(410);
      drive(3, 0, 0, 0);
      push(411, K_RDY, 0, 8'h01, 8'h00, "ch3_acc");
      push(412, K_RDY, 0, 8'h01, 8'h01, "ch3_rdy");
      push(412, K_LED, 0, 8'h07, 8'h07, "ch3_led_a");
      push(420, K_LED, 0, 8'h07, 8'h07, "ch3_led_b");
      wait_rel(411);
      cfg_if.valid = 1'b0;

      // ch0 period 4, duty 2 blink
      wait_rel(430);
      drive(0, 2, 4, 2);
      push(432, K_LED, 0, 8'h07, 8'h07, "p4d2_ph0");
      push(444, K_LED, 0, 8'h07, 8'h07, "p4d2_ph1");
      push(445, K_LED, 0, 8'h07, 8'h06, "p4d2_ph2");
      push(468, K_LED, 0, 8'h07, 8'h06, "p4d2_ph3");
      push(469, K_LED, 0, 8'h07, 8'h07, "p4d2_wrap");
      wait_rel(431);
      cfg_if.valid = 1'b0;

      // ONESHOT on ch2, 3 ticks
      wait_rel(480);
      drive(2, 3, 8, 3);
      push(482, K_LED,  0, 8'h04, 8'h04, "os_start");
      push(516, K_LED,  0, 8'h04, 8'h04, "os_last");
      push(517, K_LED,  0, 8'h04, 8'h00, "os_end");
      push(600, K_LED,  0, 8'h04, 8'h00, "os_stay");
      push(520, K_MODE, 0, 8'h03, 8'h00, "os_mode");
      wait_rel(481);
      cfg_if.valid = 1'b0;

      // Collision: ch0 write on a tick cycle
      wait_rel(610);
      drive(1, 2, 10, 5);
      wait_rel(611);
      cfg_if.valid = 1'b0;
      wait_rel(614);
      drive(2, 2, 10, 5);
      wait_rel(615);
      cfg_if.valid = 1'b0;
      wait_rel(636);
      drive(0, 2, 6, 3);
      push(637, K_PHASE, 0, 8'hff, 8'd0, "col_ph0");
      push(637, K_PHASE, 1, 8'hff, 8'd3, "col_ph1");
      push(637, K_PHASE, 2, 8'hff, 8'd2, "col_ph2");
      push(638, K_LED,   0, 8'h07, 8'h07, "col_led");
      push(647, K_PHASE, 0, 8'hff, 8'd0, "col_ph0_b");
      wait_rel(637);
      cfg_if.valid = 1'b0;

      // Asynchronous reset in the middle of a tick cycle
      wait_rel(647);
      push(648, K_LED,  0, 8'h07, 8'h00, "arst_led");
      push(648, K_TICK, 0, 8'h01, 8'h00, "arst_tick");
      push(648, K_RDY,  0, 8'h01, 8'h00, "arst_rdy");
      push(650, K_PHASE, 1, 8'hff, 8'd0, "arst_ph1");
      @(posedge clk);
      #2 rst_n = 1'b0;
      wait_rel(652);
      #2 rst_n = 1'b1;
      base = base + 652;

      // Defaults restored after the second release
      push(1,  K_RDY,   0, 8'h01, 8'h01, "r2_rdy");
      push(1,  K_LED,   0, 8'h07, 8'h07, "r2_led1");
      push(11, K_TICK,  0, 8'h01, 8'h00, "r2_tick11");
      push(12, K_TICK,  0, 8'h01, 8'h01, "r2_tick12");
      push(13, K_PHASE, 0, 8'hff, 8'd1,  "r2_ph0");
      push(40, K_LED,   0, 8'h07, 8'h07, "r2_led40");
      push(61, K_LED,   0, 8'h07, 8'h00, "r2_led61");

      wait_rel(70);
      finish_req = 1'b1;
   end

endmodule

// File: doc/multi_led_blinker.md
Name: multi_led_blinker

Overview:
Parametrised N-channel LED pattern generator, the successor to the single fixed one-second blinker.
- A shared prescaler derives a millisecond-class TICK from the board clock (12 MHz on iCESugar).
- Each channel runs its own period/duty phase counter in one of four modes: OFF, ON, BLINK, ONESHOT.
- Mode, period and duty are configured at run time through a valid/ready write port.
- Reset defaults reproduce a 1 s, 50 % blink on every channel.

Parameters:
CLK_HZ, 12000000, input clock frequency in Hz
TICK_HZ, 1000, phase tick rate in Hz; prescaler divisor DIV = CLK_HZ/TICK_HZ (integer, >= 2)
NUM_CH, 3, number of LED channels (1..8)
PERIOD_W, 12, width of period/duty/phase counters, in ticks
DEF_PERIOD, 1000, reset period in ticks for all channels
DEF_DUTY, 500, reset on-time in ticks for all channels

Ports:
CLK  input  1  system clock; all logic on rising edge
RST_N  input  1  asynchronous active-low reset
CFG_VALID  input  1  config write request
CFG_READY  output  1  config write can be accepted
CFG_CH  input  CH_W  target channel, CH_W = max(1, clog2(NUM_CH))
CFG_MODE  input  2  0 = OFF, 1 = ON, 2 = BLINK, 3 = ONESHOT
CFG_PERIOD  input  PERIOD_W  period in ticks
CFG_DUTY  input  PERIOD_W  on-time in ticks
LED  output  NUM_CH  per-channel LED drive, registered
TICK  output  1  one-CLK strobe per tick, registered

Behaviour:
- Reset (RST_N low, asynchronous):
  - Prescaler = 0, TICK = 0, CFG_READY = 0, all phases = 0.
  - Every channel: mode = BLINK, period = DEF_PERIOD, duty = DEF_DUTY.
  - LED = all 0 (inactive level).
- Release: CFG_READY rises on the first CLK edge after RST_N goes high.
- Prescaler: counts 0..DIV-1 and wraps. TICK = 1 for exactly the cycle after the count reaches DIV-1, so TICK period = DIV cycles.
- Phase per channel, advanced only on TICK cycles: phase <= (phase+1 >= period) ? 0 : phase+1. Period 0 or 1 holds phase at 0.
- LED per channel is registered and reflects the updated phase on the same edge the phase updates:
  - OFF: LED = 0.
  - ON: LED = 1.
  - BLINK: LED = (phase < duty). Duty 0 gives constant 0; duty >= period gives constant 1.
  - ONESHOT: LED = 1 while phase < duty. On the TICK where phase+1 reaches duty (or immediately if duty = 0), LED = 0, mode becomes OFF, phase = 0. Period is ignored in ONESHOT.
- Config handshake:
  - A write is accepted on an edge where CFG_VALID & CFG_READY.
  - Accepted write loads mode/period/duty for CFG_CH and clears that channel's phase.
  - The new LED value appears on the edge after the accept edge, i.e. 1 cycle latency.
  - CFG_READY = 0 for the one cycle following each accept: max one write per 2 cycles.
  - CFG_CH >= NUM_CH: write is accepted (handshake completes) and discarded.
- Simultaneous write and TICK on the same channel: the write wins, phase = 0, and that tick is not applied to the channel. Other channels advance normally.
- Reset mid-operation: all state returns to reset values immediately. No partial write survives.
- Prescaler and phase counters never overflow: comparisons use >=, with arithmetic one bit wider than PERIOD_W.

Optional Feature:
MULTI_LED_BLINKER_ACTIVE_LOW_EN
- Defined: LED outputs are inverted at the output register for the iCESugar active-low RGB LED. Reset value of LED = all 1; "on" drives 0.
- Undefined: active-high as described above.
- TICK and the handshake are unaffected either way.

Test Plan:
All scenarios use CLK_HZ=12000, TICK_HZ=1000 (DIV=12), NUM_CH=3, DEF_PERIOD=10, DEF_DUTY=5.
- Reset default: release RST_N, no writes -> TICK every 12 cycles; LED = 3'b111 for 5 ticks, then 3'b000 for 5 ticks, repeating. CFG_READY = 1 one edge after release.
- Handshake: hold CFG_VALID with ch=1, mode=ON -> accepted on first ready edge; LED[1] = 1 on the next edge; CFG_READY low exactly one cycle. A second queued write is accepted 2 cycles after the first.
- Boundaries: ch0 BLINK period=4 duty=0 -> LED[0] constant 0; duty=4 -> constant 1; period=0 duty=3 -> constant 1. ch=3 write -> LED unchanged, handshake completes.
- ONESHOT: ch2 mode=3 duty=3 -> LED[2] high for 3 ticks (36 cycles, ±1 phase alignment), then 0 and stays 0; readback of internal mode = OFF.
- Collision and reset: write to ch0 on a TICK cycle -> ch0 phase = 0 while ch1/ch2 phases advance. Assert RST_N mid-blink -> LED = 0 and TICK = 0 immediately (asynchronous).
- Build with MULTI_LED_BLINKER_ACTIVE_LOW_EN -> LED = 3'b111 during reset; the default-blink scenario shows an inverted waveform.
